// File: rtl/sdram_stream_reader.sv
// Memory-to-stream DMA reader: fetches LEN words from SDRAM over a pipelined
// Avalon-MM read master and replays them in order on an Avalon-ST source.
module sdram_stream_reader #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        slave_address,
    input  logic              slave_chipselect,
    input  logic              slave_read,
    input  logic              slave_write,
    input  logic [31:0]       slave_writedata,
    output logic [31:0]       slave_readdata,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    input  logic [DATA_W-1:0] master_readdata,
    input  logic              master_readdatavalid,
    input  logic              master_waitrequest,
    output logic [DATA_W-1:0] streaming_source_data,
    output logic              streaming_source_valid,
    input  logic              streaming_source_ready,
    output logic              irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(DATA_W / 8);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_ABORT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_reg, cur_addr;
    logic [31:0]       len_reg, issue_cnt, rx_cnt, pop_cnt;
    logic              irq_en, done;
    logic [CNT_W-1:0]  outstanding, fifo_count;
    logic [CNT_W:0]    in_use;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [15:0]       remaining;

    logic busy, reg_wr, ctrl_wr, start_cmd, go, zero_start, abort_cmd, clear_done;
    logic credit_ok, issue_fire, push, pop, rdv_absorb, drain_done;

    assign busy       = (state != S_IDLE);
    assign reg_wr     = slave_chipselect && slave_write;
    assign ctrl_wr    = reg_wr && (slave_address == 2'd2);
    assign start_cmd  = ctrl_wr && slave_writedata[0] && (state == S_IDLE);
    assign go         = start_cmd && (len_reg != '0);
    assign zero_start = start_cmd && (len_reg == '0);
    assign abort_cmd  = ctrl_wr && slave_writedata[2] && (state == S_RUN || state == S_DRAIN);
    assign clear_done = reg_wr && (slave_address == 2'd3) && slave_writedata[1];

    // Credit counts reads in flight as already occupying FIFO slots.
    assign in_use     = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit_ok  = in_use < (CNT_W+1)'(FIFO_DEPTH);
    assign issue_fire = master_read && !master_waitrequest;
    assign push       = master_readdatavalid && (state == S_RUN || state == S_DRAIN);
    assign rdv_absorb = master_readdatavalid && busy && (outstanding != '0);
    assign pop        = streaming_source_valid && streaming_source_ready;

    assign master_address         = cur_addr;
    assign streaming_source_valid = (fifo_count != '0);
    assign streaming_source_data  = streaming_source_valid ? mem[rd_ptr] : '0;
    assign irq                    = done && irq_en;
    assign remaining              = (pop_cnt > 32'h0000_FFFF) ? 16'hFFFF : pop_cnt[15:0];

    // NOTE: defaults are assigned first so every path drives every signal and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        master_read = 1'b0;
        drain_done  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (go) state_nxt = S_RUN;
            end
            S_RUN: begin
                master_read = (issue_cnt != '0) && credit_ok;
                if (abort_cmd)            state_nxt = S_ABORT;
                else if (issue_cnt == '0) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort_cmd) begin
                    state_nxt = S_ABORT;
                end else if (rx_cnt == '0 && pop_cnt == '0) begin
                    state_nxt  = S_IDLE;
                    drain_done = 1'b1;
                end
            end
            S_ABORT: begin
                if (outstanding == '0) state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            addr_reg    <= '0;
            len_reg     <= '0;
            cur_addr    <= '0;
            issue_cnt   <= '0;
            rx_cnt      <= '0;
            pop_cnt     <= '0;
            outstanding <= '0;
            irq_en      <= 1'b0;
            done        <= 1'b0;
        end else begin
            state <= state_nxt;

            if (reg_wr && !busy) begin
                if (slave_address == 2'd0) addr_reg <= ADDR_W'(slave_writedata);
                if (slave_address == 2'd1) len_reg  <= slave_writedata;
            end
            if (ctrl_wr) irq_en <= slave_writedata[1];

            if (go) begin
                cur_addr  <= addr_reg;
                issue_cnt <= len_reg;
                rx_cnt    <= len_reg;
                pop_cnt   <= len_reg;
            end else if (abort_cmd) begin
                issue_cnt <= '0;
                rx_cnt    <= '0;
                pop_cnt   <= '0;
            end else begin
                if (issue_fire) begin
                    cur_addr  <= cur_addr + ADDR_INC;
                    issue_cnt <= issue_cnt - 1'b1;
                end
                if (push && rx_cnt != '0) rx_cnt  <= rx_cnt - 1'b1;
                if (pop && pop_cnt != '0) pop_cnt <= pop_cnt - 1'b1;
            end

            case ({issue_fire, rdv_absorb})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            if (clear_done || go || abort_cmd) done <= 1'b0;
            if (zero_start || drain_done)      done <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slave_readdata <= '0;
        end else if (slave_chipselect && slave_read) begin
            case (slave_address)
                2'd0:    slave_readdata <= 32'(addr_reg);
                2'd1:    slave_readdata <= len_reg;
                2'd2:    slave_readdata <= {30'd0, irq_en, 1'b0};
                default: slave_readdata <= {remaining, 14'd0, done, busy};
            endcase
        end
    end

    // Abort flushes the buffer in the same edge it moves the FSM to ABORT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (abort_cmd) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: storage is not reset; occupancy is tracked by pointers/count, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= master_readdata;
    end

endmodule
